// File: rtl/ula_pkg.sv
// Shared definitions for the ULA arbiter: ALU op codes, widths, FSM states.
// Legal op set matches the ALU datapath this block fronts.
package ula_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic op_is_legal(
    input logic [DEF_OP_W-1:0] op
  );
    case (op)
      OP_AND, OP_OR, OP_ADD,
      OP_SUB, OP_SLT: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the favoured requester.
// A grant with advance set hands preference to the other requester.
module ula_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00))
      ptr_d = gnt[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one ALU between two requesters with valid/ready handshakes.
// Define ULA_ARB_STATS_EN to add per-requester completion counters.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_srca,
  input  logic [2*DATA_W-1:0] req_srcb,
  input  logic [2*OP_W-1:0]   req_op,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_z,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   alu_srca,
  output logic [DATA_W-1:0]   alu_srcb,
  output logic [OP_W-1:0]     alu_ctrl,
  input  logic [DATA_W-1:0]   alu_rslt,
  input  logic                alu_z
`ifdef ULA_ARB_STATS_EN
  ,
  output logic [15:0]         stat_cnt0,
  output logic [15:0]         stat_cnt1
`endif
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_z_q, rsp_z_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] alu_srca_q, alu_srca_d;
  logic [DATA_W-1:0] alu_srcb_q, alu_srcb_d;
  logic [OP_W-1:0]   alu_ctrl_q, alu_ctrl_d;

  logic [1:0]        arb_req;
  logic              arb_adv;
  logic [1:0]        gnt;
  logic              g;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;

  // Arbitration only happens in IDLE and never while reset is held.
  assign arb_adv = rst && (state_q == ST_IDLE);
  assign arb_req = arb_adv ? req_valid : 2'b00;

  ula_rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (arb_adv),
    .gnt     (gnt)
  );

  assign g      = gnt[1];
  assign sel_a  = g ? req_srca[DATA_W +: DATA_W]
                    : req_srca[0 +: DATA_W];
  assign sel_b  = g ? req_srcb[DATA_W +: DATA_W]
                    : req_srcb[0 +: DATA_W];
  assign sel_op = g ? req_op[OP_W +: OP_W]
                    : req_op[0 +: OP_W];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_z_d     = rsp_z_q;
    rsp_err_d   = rsp_err_q;
    alu_srca_d  = alu_srca_q;
    alu_srcb_d  = alu_srcb_q;
    alu_ctrl_d  = alu_ctrl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = g;
          if (op_is_legal(sel_op)) begin
            alu_srca_d = sel_a;
            alu_srcb_d = sel_b;
            alu_ctrl_d = sel_op;
            state_d    = ST_ISSUE;
          end else begin
            rsp_data_d  = '0;
            rsp_z_d     = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = gnt;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        rsp_data_d  = alu_rslt;
        rsp_z_d     = alu_z;
        rsp_err_d   = 1'b0;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_z_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_srca_q  <= '0;
      alu_srcb_q  <= '0;
      alu_ctrl_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_z_q     <= rsp_z_d;
      rsp_err_q   <= rsp_err_d;
      alu_srca_q  <= alu_srca_d;
      alu_srcb_q  <= alu_srcb_d;
      alu_ctrl_q  <= alu_ctrl_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_err   = rsp_err_q;
  assign alu_srca  = alu_srca_q;
  assign alu_srcb  = alu_srcb_q;
  assign alu_ctrl  = alu_ctrl_q;

`ifdef ULA_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic [1:0]  done;

  assign done = rsp_valid_q & rsp_ready;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (done[0] && (cnt0_q != 16'hFFFF))
      cnt0_d = cnt0_q + 16'd1;
    if (done[1] && (cnt1_q != 16'hFFFF))
      cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model and a behavioural ALU.
module tb_ula_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_srca;
  logic [15:0] req_srcb;
  logic [5:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_z;
  logic        rsp_err;
  logic [7:0]  alu_srca;
  logic [7:0]  alu_srcb;
  logic [2:0]  alu_ctrl;
  logic [7:0]  alu_rslt;
  logic        alu_z;
`ifdef ULA_ARB_STATS_EN
  logic [15:0] stat_cnt0;
  logic [15:0] stat_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  int         pref;
  logic [7:0] last_a;
  logic [7:0] last_b;
  logic [2:0] last_ctrl;
  int         cnt [2];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_rslt = alu_ref(alu_ctrl, alu_srca, alu_srcb);
  assign alu_z    = (alu_rslt == 8'h00);

  ula_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_srca  (req_srca),
    .req_srcb  (req_srcb),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_z     (rsp_z),
    .rsp_err   (rsp_err),
    .alu_srca  (alu_srca),
    .alu_srcb  (alu_srcb),
    .alu_ctrl  (alu_ctrl),
    .alu_rslt  (alu_rslt),
    .alu_z     (alu_z)
`ifdef ULA_ARB_STATS_EN
    ,
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rv"},  rsp_valid, 0);
    chk({tag, "_rr"},  req_ready, 0);
    chk({tag, "_rd"},  rsp_data, 0);
    chk({tag, "_rz"},  rsp_z, 0);
    chk({tag, "_re"},  rsp_err, 0);
    chk({tag, "_sa"},  alu_srca, 0);
    chk({tag, "_sb"},  alu_srcb, 0);
    chk({tag, "_ctl"}, alu_ctrl, 0);
  endtask

  task automatic model_reset();
    pref      = 0;
    last_a    = 8'h00;
    last_b    = 8'h00;
    last_ctrl = 3'b000;
    cnt[0]    = 0;
    cnt[1]    = 0;
  endtask

  // One full transaction starting in IDLE; hold = cycles rsp_ready is withheld.
  task automatic run_op(
    input logic [1:0] v,
    input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] o0,
    input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] o1,
    input int         hold
  );
    int         w;
    logic [1:0] oh;
    logic [7:0] a, b, d;
    logic [2:0] o;
    logic       legal;
    w  = (v == 2'b11) ? pref : (v[0] ? 0 : 1);
    oh = (w == 0) ? 2'b01 : 2'b10;
    a  = (w == 0) ? a0 : a1;
    b  = (w == 0) ? b0 : b1;
    o  = (w == 0) ? o0 : o1;
    legal = (o inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});
    req_valid = v;
    req_srca  = {a1, a0};
    req_srcb  = {b1, b0};
    req_op    = {o1, o0};
    rsp_ready = 2'b00;
    #1;
    chk("grant", req_ready, oh);
    step();
    pref = 1 - w;
    req_valid = v & ~oh;
    #1;
    chk("no_ready_busy", req_ready, 0);
    if (legal) begin
      chk("issue_ctrl", alu_ctrl, o);
      chk("issue_srca", alu_srca, a);
      chk("issue_srcb", alu_srcb, b);
      chk("issue_rv", rsp_valid, 0);
      last_a = a;
      last_b = b;
      last_ctrl = o;
      d = alu_ref(o, a, b);
      step();
      chk("rsp_rv", rsp_valid, oh);
      chk("rsp_data", rsp_data, d);
      chk("rsp_z", rsp_z, (d == 8'h00));
      chk("rsp_err", rsp_err, 0);
    end else begin
      d = 8'h00;
      chk("ill_ctrl_hold", alu_ctrl, last_ctrl);
      chk("ill_srca_hold", alu_srca, last_a);
      chk("ill_rv", rsp_valid, oh);
      chk("ill_data", rsp_data, 0);
      chk("ill_z", rsp_z, 0);
      chk("ill_err", rsp_err, 1);
    end
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~oh;
      step();
      chk("hold_rv", rsp_valid, oh);
      chk("hold_data", rsp_data, d);
      chk("hold_err", rsp_err, legal ? 0 : 1);
      chk("hold_rr", req_ready, 0);
    end
    rsp_ready = oh;
    step();
    rsp_ready = 2'b00;
    chk("done_rv", rsp_valid, 0);
    chk("done_err", rsp_err, 0);
    cnt[w] = cnt[w] + 1;
  endtask

  initial begin
    logic [1:0] rv;
    model_reset();
    rst       = 1'b0;
    req_valid = 2'b11;
    req_srca  = '0;
    req_srcb  = '0;
    req_op    = '0;
    rsp_ready = 2'b00;
    step();
    step();
    chk_all_zero("reset");
`ifdef ULA_ARB_STATS_EN
    chk("reset_cnt0", stat_cnt0, 0);
    chk("reset_cnt1", stat_cnt1, 0);
`endif
    rst = 1'b1;
    req_valid = 2'b00;
    step();

    run_op(2'b01, 8'd5, 8'd3, 3'b010, 8'd0, 8'd0, 3'b000, 0);
    run_op(2'b10, 8'd0, 8'd0, 3'b000, 8'h11, 8'h22, 3'b100, 0);
    run_op(2'b11, 8'd7, 8'd7, 3'b110, 8'hF0, 8'h0F, 3'b001, 0);
    run_op(2'b10, 8'd7, 8'd7, 3'b110, 8'hF0, 8'h0F, 3'b001, 1);
    run_op(2'b11, 8'd7, 8'd7, 3'b110, 8'hF0, 8'h0F, 3'b001, 0);
    run_op(2'b10, 8'd0, 8'd0, 3'b000, 8'h3C, 8'h0F, 3'b000, 0);
    run_op(2'b11, 8'd3, 8'd9, 3'b111, 8'hAA, 8'h55, 3'b010, 5);
    run_op(2'b10, 8'd3, 8'd9, 3'b111, 8'hAA, 8'h55, 3'b010, 0);

    req_valid = 2'b01;
    req_srca  = {8'd0, 8'd40};
    req_srcb  = {8'd0, 8'd2};
    req_op    = {3'b000, 3'b010};
    #1;
    chk("pre_rst_grant", req_ready, (pref == 0 || 1) ? 2'b01 : 2'b01);
    step();
    req_valid = 2'b11;
    rst = 1'b0;
    step();
    model_reset();
    chk_all_zero("mid_rst");
    rst = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_rv", rsp_valid, 0);
    end
    run_op(2'b11, 8'd1, 8'd1, 3'b110, 8'd9, 8'd9, 3'b010, 0);

    for (int n = 0; n < 40; n++) begin
      rv = 2'($urandom_range(1, 3));
      run_op(rv,
             8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
             8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
             $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 2'b00;
        #1;
        chk("idle_rr", req_ready, 0);
        step();
        chk("idle_rv", rsp_valid, 0);
      end
    end

`ifdef ULA_ARB_STATS_EN
    chk("stat_cnt0", stat_cnt0, cnt[0]);
    chk("stat_cnt1", stat_cnt1, cnt[1]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
